// File: rtl/twos_pkg.sv
// Shared definitions for the two's-complement unit: mode codes and FSM encoding.
package twos_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS = 2'b00;
  localparam mode_t MODE_NEG  = 2'b01;
  localparam mode_t MODE_ABS  = 2'b10;
  localparam mode_t MODE_ONES = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder used as the ripple cell of the chunk slice.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/twos_chunk.sv
// CHUNK-bit invert-and-add slice: y = (inv ? ~a : a) + cin, with carry-out.
module twos_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic             i_inv,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_y,
  output logic             o_cout
);

  logic [CHUNK:0]   w_carry;
  logic [CHUNK-1:0] w_aInv;

  assign w_carry[0] = i_cin;
  assign w_aInv     = i_inv ? ~i_a : i_a;
  assign o_cout     = w_carry[CHUNK];

  // Ripple the carry through one full adder per bit; the second addend is zero.
  for (genvar g = 0; g < CHUNK; g++) begin : gRipple
    fulladder uFa (
      .i_a    (w_aInv[g]),
      .i_b    (1'b0),
      .i_cin  (w_carry[g]),
      .o_s    (o_y[g]),
      .o_cout (w_carry[g+1])
    );
  end

endmodule

// File: rtl/twos_comp_unit.sv
// Multi-cycle two's-complement unit: pass / negate / abs / ones' complement,
// processed CHUNK bits per cycle LSB first, with valid/ready on both sides.
module twos_comp_unit
  import twos_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_inv;
  logic             r_ovfPend;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_outData;
  logic             r_outOvf;
  logic             r_outValid;

  logic [CHUNK-1:0]       w_y;
  logic                   w_cout;
  logic [WIDTH+CHUNK-1:0] w_resNext;
  logic                   w_inv;
  logic                   w_carry0;
  logic                   w_ovf;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_ovf   = r_outOvf;

  // New chunk enters at the top so after NCHUNK shifts the result is aligned.
  assign w_resNext = {w_y, r_res};

  twos_chunk #(.CHUNK(CHUNK)) uChunk (
    .i_a    (r_op[CHUNK-1:0]),
    .i_inv  (r_inv),
    .i_cin  (r_carry),
    .o_y    (w_y),
    .o_cout (w_cout)
  );

  // Decode the accepted mode into invert/carry-in controls and the overflow flag.
  always_comb begin
    w_inv    = 1'b0;
    w_carry0 = 1'b0;
    w_ovf    = 1'b0;
    case (in_mode)
      MODE_NEG: begin
        w_inv    = 1'b1;
        w_carry0 = 1'b1;
        w_ovf    = (in_data == MIN_VAL);
      end
      MODE_ABS: begin
        w_inv    = in_data[WIDTH-1];
        w_carry0 = in_data[WIDTH-1];
        w_ovf    = (in_data == MIN_VAL);
      end
      MODE_ONES: begin
        w_inv    = 1'b1;
      end
      default: begin
        w_inv    = 1'b0;
      end
    endcase
  end

  // Control FSM plus the operand/result shift registers and the chunk carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_inv      <= 1'b0;
      r_ovfPend  <= 1'b0;
      r_op       <= '0;
      r_res      <= '0;
      r_outData  <= '0;
      r_outOvf   <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op      <= in_data;
            r_inv     <= w_inv;
            r_carry   <= w_carry0;
            r_ovfPend <= w_ovf;
            r_idx     <= '0;
            r_res     <= '0;
            r_state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_res   <= w_resNext[WIDTH+CHUNK-1:CHUNK];
          r_op    <= r_op >> CHUNK;
          r_carry <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_outData  <= w_resNext[WIDTH+CHUNK-1:CHUNK];
            r_outOvf   <= r_ovfPend;
            r_outValid <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
